// File: rtl/rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// rx_pkt_ctrl : frames A5/len/payload[/checksum] packets and drains them out.
// Optional checksum byte and CKSUM state are compiled in with RX_PKT_CKSUM_EN.
// Revision: 1.0
// ============================================================================
module rx_pkt_ctrl #(
   parameter int MAX_LEN     = 16,
   parameter int TIMEOUT_CYC = 2000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_char,
   input  logic       i_char_valid,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_byte_last,
   input  logic       i_byte_ready,
   output logic       o_busy,
   output logic [2:0] o_err,
   output logic       o_overrun
);
   localparam int             IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int             DEPTH    = 1 << IW;
   localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]     MAX_L    = 8'(MAX_LEN);
   localparam logic [7:0]     HDR      = 8'hA5;
   localparam logic [IW-1:0]  IDX0     = '0;

   typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CKSUM, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic [7:0]    sum_q, sum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic          busy_q, busy_d;
   logic [2:0]    err_q, err_d;
   logic          overrun_q, overrun_d;
   logic          wr_en;
   logic [IW-1:0] rd_nxt;
   logic [7:0]    buf_q [DEPTH];
`ifdef RX_PKT_CKSUM_EN
   logic [7:0]    ck_sum;
`endif

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      rd_idx_d  = rd_idx_q;
      sum_d     = sum_q;
      tmo_d     = '0;
      byte_d    = byte_q;
      last_d    = last_q;
      err_d     = '0;
      overrun_d = 1'b0;
      wr_en     = 1'b0;
      rd_nxt    = rd_idx_q + 1'b1;
`ifdef RX_PKT_CKSUM_EN
      ck_sum    = sum_q + i_char;
`endif
      case (state_q)
         HUNT: begin
            if (i_char_valid && i_char == HDR) state_d = LEN;
         end
         DRAIN: begin
            overrun_d = i_char_valid;
            if (i_byte_ready) begin
               if (last_q) begin
                  state_d = HUNT;
               end else begin
                  rd_idx_d = rd_nxt;
                  byte_d   = buf_q[rd_nxt];
                  last_d   = (8'(rd_nxt) == len_q - 8'd1);
               end
            end
         end
         LEN, PAYLOAD, CKSUM: begin
            if (!i_char_valid) begin
               // Partial packet is abandoned once the line has been idle too long
               if (tmo_q == TMO_LAST) begin
                  err_d[2] = 1'b1;
                  state_d  = HUNT;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end else if (state_q == LEN) begin
               if (i_char == 8'd0 || i_char > MAX_L) begin
                  err_d[0] = 1'b1;
                  state_d  = HUNT;
               end else begin
                  len_d   = i_char;
                  idx_d   = '0;
                  sum_d   = '0;
                  state_d = PAYLOAD;
               end
            end else if (state_q == PAYLOAD) begin
               wr_en = 1'b1;
               sum_d = sum_q + i_char;
               idx_d = idx_q + 1'b1;
               if (8'(idx_q) == len_q - 8'd1) begin
`ifdef RX_PKT_CKSUM_EN
                  state_d = CKSUM;
`else
                  // The only byte may still be in flight to the buffer
                  state_d  = DRAIN;
                  rd_idx_d = '0;
                  byte_d   = (len_q == 8'd1) ? i_char : buf_q[IDX0];
                  last_d   = (len_q == 8'd1);
`endif
               end
            end else begin
`ifdef RX_PKT_CKSUM_EN
               if (ck_sum == 8'd0) begin
                  state_d  = DRAIN;
                  rd_idx_d = '0;
                  byte_d   = buf_q[IDX0];
                  last_d   = (len_q == 8'd1);
               end else begin
                  err_d[1] = 1'b1;
                  state_d  = HUNT;
               end
`else
               state_d = HUNT;
`endif
            end
         end
         default: state_d = HUNT;
      endcase
      if (state_d != DRAIN) begin
         byte_d = '0;
         last_d = 1'b0;
      end
      valid_d = (state_d == DRAIN);
      busy_d  = (state_d != HUNT);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= HUNT;
         len_q     <= '0;
         idx_q     <= '0;
         rd_idx_q  <= '0;
         sum_q     <= '0;
         tmo_q     <= '0;
         byte_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         rd_idx_q  <= rd_idx_d;
         sum_q     <= sum_d;
         tmo_q     <= tmo_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) buf_q[idx_q] <= i_char;
   end

   assign o_byte       = byte_q;
   assign o_byte_valid = valid_q;
   assign o_byte_last  = last_q;
   assign o_busy       = busy_q;
   assign o_err        = err_q;
   assign o_overrun    = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rx_pkt_ctrl : directed packet vectors plus stall, timeout and reset cases.
// Revision: 1.0
// ============================================================================
module tb_rx_pkt_ctrl;
`ifdef RX_PKT_CKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   localparam int TMO = 2000;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic [7:0] i_char = '0;
   logic       i_char_valid = 1'b0;
   logic [7:0] o_byte;
   logic       o_byte_valid;
   logic       o_byte_last;
   logic       i_byte_ready = 1'b1;
   logic       o_busy;
   logic [2:0] o_err;
   logic       o_overrun;

   rx_pkt_ctrl #(.MAX_LEN(16), .TIMEOUT_CYC(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_char(i_char), .i_char_valid(i_char_valid),
      .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_byte_last(o_byte_last),
      .i_byte_ready(i_byte_ready), .o_busy(o_busy), .o_err(o_err), .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [4:0]        nch;
      logic              add_ck;
      logic [7:0]        ck;
      logic [2:0]        poff;
      logic [2:0]        exp_err;
      logic [4:0]        exp_n;
      logic [23:0][7:0]  ch;
   } vec_t;

   vec_t vt [6];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [7:0] got_b [32];
   logic       got_l [32];
   int         mon_n = 0;
   logic [2:0] err_or = '0;
   int         err_pulses = 0;
   int         ovr_cnt = 0;

   always @(negedge i_clk) begin
      if (i_rst) begin
         if (o_byte_valid && i_byte_ready) begin
            if (mon_n < 32) begin
               got_b[mon_n] = o_byte;
               got_l[mon_n] = o_byte_last;
            end
            mon_n++;
         end
         if (o_err != 3'b000) begin
            err_or = err_or | o_err;
            err_pulses++;
         end
         if (o_overrun) ovr_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mon_clear();
      mon_n = 0; err_or = '0; err_pulses = 0; ovr_cnt = 0;
   endtask

   task automatic send_char(input logic [7:0] c);
      @(posedge i_clk); #2;
      i_char = c; i_char_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      @(posedge i_clk); #2;
      i_char_valid = 1'b0; i_char = '0;
      repeat (n) @(posedge i_clk);
      #2;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      mon_clear();
      for (int i = 0; i < int'(v.nch); i++) send_char(v.ch[i]);
      if (CK && v.add_ck) send_char(v.ck);
      idle(30);
      chk({nm, " err"}, 32'(err_or), 32'(v.exp_err));
      chk({nm, " err_pulses"}, err_pulses, (v.exp_err != 3'b000) ? 1 : 0);
      chk({nm, " nbytes"}, mon_n, 32'(v.exp_n));
      for (int i = 0; i < int'(v.exp_n) && i < mon_n; i++) begin
         chk($sformatf("%s byte%0d", nm, i), 32'(got_b[i]), 32'(v.ch[int'(v.poff) + i]));
         chk($sformatf("%s last%0d", nm, i), 32'(got_l[i]), (i == int'(v.exp_n) - 1) ? 1 : 0);
      end
      chk({nm, " busy_end"}, 32'(o_busy), 0);
      chk({nm, " overrun"}, ovr_cnt, 0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " byte"}, 32'(o_byte), 0);
      chk({nm, " valid"}, 32'(o_byte_valid), 0);
      chk({nm, " last"}, 32'(o_byte_last), 0);
      chk({nm, " busy"}, 32'(o_busy), 0);
      chk({nm, " err"}, 32'(o_err), 0);
      chk({nm, " overrun"}, 32'(o_overrun), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_n;
      vt[0] = '0; vt[0].nch = 5; vt[0].add_ck = 1; vt[0].ck = 8'h9A; vt[0].poff = 2;
      vt[0].exp_n = 3;
      vt[0].ch[0] = 8'hA5; vt[0].ch[1] = 8'h03; vt[0].ch[2] = 8'h11;
      vt[0].ch[3] = 8'h22; vt[0].ch[4] = 8'h33;

      vt[1] = '0; vt[1].nch = 4; vt[1].add_ck = 1; vt[1].ck = 8'h00; vt[1].poff = 2;
      vt[1].exp_err = CK ? 3'b010 : 3'b000; vt[1].exp_n = CK ? 5'd0 : 5'd2;
      vt[1].ch[0] = 8'hA5; vt[1].ch[1] = 8'h02; vt[1].ch[2] = 8'h10; vt[1].ch[3] = 8'h20;

      vt[2] = '0; vt[2].nch = 2; vt[2].exp_err = 3'b001;
      vt[2].ch[0] = 8'hA5; vt[2].ch[1] = 8'h00;

      vt[3] = '0; vt[3].nch = 2; vt[3].exp_err = 3'b001;
      vt[3].ch[0] = 8'hA5; vt[3].ch[1] = 8'h11;

      vt[4] = '0; vt[4].nch = 5; vt[4].add_ck = 1; vt[4].ck = 8'h82; vt[4].poff = 4;
      vt[4].exp_n = 1;
      vt[4].ch[0] = 8'h00; vt[4].ch[1] = 8'hFF; vt[4].ch[2] = 8'hA5;
      vt[4].ch[3] = 8'h01; vt[4].ch[4] = 8'h7E;

      vt[5] = '0; vt[5].nch = 18; vt[5].add_ck = 1; vt[5].ck = 8'h88; vt[5].poff = 2;
      vt[5].exp_n = 16;
      vt[5].ch[0] = 8'hA5; vt[5].ch[1] = 8'h10;
      for (int i = 0; i < 16; i++) vt[5].ch[2 + i] = 8'(i);

      // Reset state
      repeat (3) @(posedge i_clk);
      #2;
      chk_all_zero("reset");
      i_rst = 1'b1;
      idle(2);

      for (int k = 0; k < 6; k++) run_vec(vt[k], $sformatf("vec%0d", k));

      // Inter-character timeout, then recovery
      mon_clear();
      send_char(8'hA5); send_char(8'h04); send_char(8'h01); send_char(8'h02);
      @(posedge i_clk); #2;
      i_char_valid = 1'b0;
      first_n = -1;
      for (int n = 1; n <= TMO + 100 && first_n < 0; n++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         if (o_err[2]) first_n = n;
      end
      chk("tmo first_edge", first_n, TMO);
      idle(3);
      chk("tmo pulses", err_pulses, 1);
      chk("tmo err_bits", 32'(err_or), 32'(3'b100));
      chk("tmo busy", 32'(o_busy), 0);
      run_vec(vt[0], "after_tmo");

      // Consumer stall with a character injected during DRAIN
      mon_clear();
      i_byte_ready = 1'b0;
      send_char(8'hA5); send_char(8'h02); send_char(8'h5A); send_char(8'hC3);
      if (CK) send_char(8'hE3);
      @(posedge i_clk); #2;
      i_char_valid = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge i_clk);
         chk($sformatf("stall valid%0d", s), 32'(o_byte_valid), 1);
         chk($sformatf("stall byte%0d", s), 32'(o_byte), 32'h5A);
         chk($sformatf("stall last%0d", s), 32'(o_byte_last), 0);
         @(posedge i_clk); #2;
         i_char_valid = (s == 1);
         i_char = (s == 1) ? 8'hA5 : 8'h00;
      end
      i_byte_ready = 1'b1;
      i_char_valid = 1'b0;
      idle(10);
      chk("stall nbytes", mon_n, 2);
      chk("stall b0", 32'(got_b[0]), 32'h5A);
      chk("stall l0", 32'(got_l[0]), 0);
      chk("stall b1", 32'(got_b[1]), 32'hC3);
      chk("stall l1", 32'(got_l[1]), 1);
      chk("stall overrun", ovr_cnt, 1);
      chk("stall busy_end", 32'(o_busy), 0);
      chk("stall err", err_pulses, 0);

      // Reset mid-payload
      mon_clear();
      send_char(8'hA5); send_char(8'h04); send_char(8'h01); send_char(8'h02);
      @(posedge i_clk); #2;
      i_char_valid = 1'b0;
      i_rst = 1'b0;
      @(posedge i_clk); @(negedge i_clk);
      chk_all_zero("midrst");
      @(posedge i_clk); #2;
      i_rst = 1'b1;
      run_vec(vt[0], "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
